// File: rtl/pipe_slice.sv
// Valid/ready register slice: forward, backward or full-skid mode, cascaded 1..4 stages.
// Optional statistics (beat_cnt, occ) are compiled in with `define PIPE_SLICE_STATS_EN.

module pipe_slice_stage #(
  parameter int L    = 8,
  parameter int MODE = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_f,
  input  logic [L-1:0] data_f,
  output logic         ready_f,
  output logic         valid_b,
  output logic [L-1:0] data_b,
  input  logic         ready_b
);

  typedef enum logic [1:0] {S_EMPTY, S_BUSY, S_FULL} state_t;

  if (MODE == 0) begin : g_fwd
    logic         vld_q;
    logic [L-1:0] dat_q;
    logic         in_x;

    assign ready_f = rst && (ready_b || !vld_q);
    assign in_x    = valid_f && ready_f;
    assign valid_b = vld_q;
    assign data_b  = dat_q;

    always_ff @(posedge clk) begin
      if (!rst)          vld_q <= 1'b0;
      else if (in_x)     vld_q <= 1'b1;
      else if (ready_b)  vld_q <= 1'b0;
    end

    always_ff @(posedge clk) begin
      if (in_x) dat_q <= data_f;
    end

  end else if (MODE == 1) begin : g_bwd
    logic         sk_v_q;
    logic [L-1:0] sk_q;
    logic         in_x;

    // Ready comes straight off the skid flag; rst only forces it low.
    assign ready_f = rst && !sk_v_q;
    assign in_x    = valid_f && ready_f;
    assign valid_b = sk_v_q || in_x;
    assign data_b  = sk_v_q ? sk_q : data_f;

    always_ff @(posedge clk) begin
      if (!rst)                  sk_v_q <= 1'b0;
      else if (in_x && !ready_b) sk_v_q <= 1'b1;
      else if (ready_b)          sk_v_q <= 1'b0;
    end

    always_ff @(posedge clk) begin
      if (in_x && !ready_b) sk_q <= data_f;
    end

  end else begin : g_skid
    state_t       state_q, state_d;
    logic [L-1:0] ob_q, sk_q;
    logic         ld_ob_in, ld_ob_sk, ld_sk;
    logic         in_x, out_x;

    assign ready_f = rst && (state_q != S_FULL);
    assign valid_b = (state_q != S_EMPTY);
    assign data_b  = ob_q;
    assign in_x    = valid_f && ready_f;
    assign out_x   = valid_b && ready_b;

    always_ff @(posedge clk) begin
      if (!rst) state_q <= S_EMPTY;
      else      state_q <= state_d;
    end

    always_comb begin
      state_d  = state_q;
      ld_ob_in = 1'b0;
      ld_ob_sk = 1'b0;
      ld_sk    = 1'b0;
      case (state_q)
        S_EMPTY: begin
          if (in_x) begin
            ld_ob_in = 1'b1;
            state_d  = S_BUSY;
          end
        end
        S_BUSY: begin
          if (in_x && out_x) begin
            ld_ob_in = 1'b1;
          end else if (in_x) begin
            ld_sk   = 1'b1;
            state_d = S_FULL;
          end else if (out_x) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          // ready_f is low here, so only the downstream side can move.
          if (out_x) begin
            ld_ob_sk = 1'b1;
            state_d  = S_BUSY;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end

    always_ff @(posedge clk) begin
      if (ld_ob_in)      ob_q <= data_f;
      else if (ld_ob_sk) ob_q <= sk_q;
      if (ld_sk)         sk_q <= data_f;
    end
  end

endmodule

module pipe_slice #(
  parameter int L      = 8,
  parameter int MODE   = 2,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              valid_f,
  input  logic [L-1:0]                      data_f,
  output logic                              ready_f,
  output logic                              valid_b,
  output logic [L-1:0]                      data_b,
  input  logic                              ready_b
`ifdef PIPE_SLICE_STATS_EN
  ,
  output logic [CNT_W-1:0]                  beat_cnt,
  output logic [$clog2(2*STAGES+1)-1:0]     occ
`endif
);

  if (L < 1 || MODE < 0 || MODE > 2 || STAGES < 1 || STAGES > 4) begin : g_bad_cfg
    $error("pipe_slice: need L>=1, MODE in 0..2, STAGES in 1..4");
  end

  // Stage k's downstream side feeds stage k+1's upstream side.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic         vld_in, rdy_out, vld_out, rdy_in;
    logic [L-1:0] dat_in, dat_out;

    if (k == 0) begin : g_head
      assign vld_in = valid_f;
      assign dat_in = data_f;
    end else begin : g_link
      assign vld_in = g_st[k-1].vld_out;
      assign dat_in = g_st[k-1].dat_out;
    end

    if (k == STAGES - 1) begin : g_tail
      assign rdy_in = ready_b;
    end else begin : g_next
      assign rdy_in = g_st[k+1].rdy_out;
    end

    pipe_slice_stage #(
      .L    (L),
      .MODE (MODE)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .valid_f (vld_in),
      .data_f  (dat_in),
      .ready_f (rdy_out),
      .valid_b (vld_out),
      .data_b  (dat_out),
      .ready_b (rdy_in)
    );
  end

  assign ready_f = g_st[0].rdy_out;
  assign valid_b = g_st[STAGES-1].vld_out;
  assign data_b  = g_st[STAGES-1].dat_out;

`ifdef PIPE_SLICE_STATS_EN
  localparam int OCC_W = $clog2(2*STAGES+1);

  logic [CNT_W-1:0] beat_q;
  logic [OCC_W-1:0] occ_q;
  logic             in_top, out_top;

  assign in_top  = valid_f && ready_f;
  assign out_top = valid_b && ready_b;

  always_ff @(posedge clk) begin
    if (!rst) begin
      beat_q <= '0;
      occ_q  <= '0;
    end else begin
      if (out_top) beat_q <= beat_q + CNT_W'(1);
      if (in_top && !out_top)      occ_q <= occ_q + OCC_W'(1);
      else if (!in_top && out_top) occ_q <= occ_q - OCC_W'(1);
    end
  end

  assign beat_cnt = beat_q;
  assign occ      = occ_q;
`endif

endmodule

// File: tb/tb_pipe_slice.sv
// Bench for pipe_slice: three instances (MODE0 x4 stages, MODE1, MODE2), vector table,
// directed corner sequences and random traffic against a queue-based reference model.

module tb_pipe_slice;
  localparam int CW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] vf, rb, rf, vb;
  logic [7:0] df [3];
  logic [7:0] db [3];
`ifdef PIPE_SLICE_STATS_EN
  logic [CW-1:0] bc [3];
  logic [3:0]    oc0;
  logic [1:0]    oc1, oc2;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_slice #(.L(8), .MODE(0), .STAGES(4), .CNT_W(CW)) u_m0 (
    .clk(clk), .rst(rst), .valid_f(vf[0]), .data_f(df[0]), .ready_f(rf[0]),
    .valid_b(vb[0]), .data_b(db[0]), .ready_b(rb[0])
`ifdef PIPE_SLICE_STATS_EN
    , .beat_cnt(bc[0]), .occ(oc0)
`endif
  );

  pipe_slice #(.L(8), .MODE(1), .STAGES(1), .CNT_W(CW)) u_m1 (
    .clk(clk), .rst(rst), .valid_f(vf[1]), .data_f(df[1]), .ready_f(rf[1]),
    .valid_b(vb[1]), .data_b(db[1]), .ready_b(rb[1])
`ifdef PIPE_SLICE_STATS_EN
    , .beat_cnt(bc[1]), .occ(oc1)
`endif
  );

  pipe_slice #(.L(8), .MODE(2), .STAGES(1), .CNT_W(CW)) u_m2 (
    .clk(clk), .rst(rst), .valid_f(vf[2]), .data_f(df[2]), .ready_f(rf[2]),
    .valid_b(vb[2]), .data_b(db[2]), .ready_b(rb[2])
`ifdef PIPE_SLICE_STATS_EN
    , .beat_cnt(bc[2]), .occ(oc2)
`endif
  );

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Upstream readiness from the number of words the slice holds:
  // MODE0 x4 has one word per stage and a ready chain that passes ready_b through.
  function automatic logic exp_ready(int m, int sz, logic r);
    case (m)
      0:       return (sz < 4) || r;
      1:       return sz < 1;
      default: return sz < 2;
    endcase
  endfunction

`ifdef PIPE_SLICE_STATS_EN
  function automatic int occ_of(int m);
    case (m)
      0:       return int'(oc0);
      1:       return int'(oc1);
      default: return int'(oc2);
    endcase
  endfunction
`endif

  for (genvar m = 0; m < 3; m++) begin : g_mon
    logic [7:0] q[$];
    int         beats;
    logic       pv, prst;
    logic [7:0] pd;
    int         sz0;
    logic       inx, outx;

    initial begin
      beats = 0;
      pv    = 1'b0;
      prst  = 1'b1;
      pd    = '0;
    end

    always @(negedge clk) begin
      sz0 = q.size();
      if (!rst) begin
        if (!prst) begin
          chk($sformatf("rst_vld%0d", m), vb[m], 0);
          chk($sformatf("rst_rdy%0d", m), rf[m], 0);
        end
        q.delete();
        beats = 0;
        pv    = 1'b0;
      end else begin
        inx  = vf[m] && rf[m];
        outx = vb[m] && rb[m];
        chk($sformatf("rdy%0d", m), rf[m], exp_ready(m, sz0, rb[m]));
        if (pv) begin
          chk($sformatf("hold_v%0d", m), vb[m], 1);
          chk($sformatf("hold_d%0d", m), db[m], pd);
        end
`ifdef PIPE_SLICE_STATS_EN
        chk($sformatf("beat%0d", m), bc[m], beats % (1 << CW));
        chk($sformatf("occ%0d", m), occ_of(m), sz0);
`endif
        if (inx) q.push_back(df[m]);
        if (vb[m]) begin
          chk($sformatf("nonempty%0d", m), q.size() > 0, 1);
          if (q.size() > 0) chk($sformatf("order%0d", m), db[m], q[0]);
        end
        if (outx && q.size() > 0) begin
          void'(q.pop_front());
          beats++;
        end
        pv = vb[m] && !rb[m];
        pd = db[m];
      end
      prst = rst;
    end
  end

  typedef struct {
    int         m;
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       e_rdy;
    logic       e_vld;
    logic [7:0] e_dat;
  } vec_t;

  function automatic vec_t mk(int m, logic v, logic [7:0] d, logic r,
                              logic er, logic ev, logic [7:0] ed);
    vec_t t;
    t.m = m; t.v = v; t.d = d; t.r = r;
    t.e_rdy = er; t.e_vld = ev; t.e_dat = ed;
    return t;
  endfunction

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    vf = '0;
    rb = '0;
    for (int i = 0; i < 3; i++) df[i] = '0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    vec_t tbl[$];
    int   lat;
    logic pend;

    rst = 1'b0;
    idle_all();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // MODE2 stall scenario, then MODE1 skid scenario.
    tbl.push_back(mk(2, 1, 8'h01, 1, 1, 0, 8'h00));
    tbl.push_back(mk(2, 1, 8'h02, 1, 1, 1, 8'h01));
    tbl.push_back(mk(2, 1, 8'h03, 0, 1, 1, 8'h02));
    tbl.push_back(mk(2, 1, 8'h04, 0, 0, 1, 8'h02));
    tbl.push_back(mk(2, 1, 8'h04, 0, 0, 1, 8'h02));
    tbl.push_back(mk(2, 1, 8'h04, 1, 0, 1, 8'h02));
    tbl.push_back(mk(2, 1, 8'h04, 1, 1, 1, 8'h03));
    tbl.push_back(mk(2, 0, 8'h00, 1, 1, 1, 8'h04));
    tbl.push_back(mk(2, 0, 8'h00, 1, 1, 0, 8'h00));
    tbl.push_back(mk(1, 1, 8'hA5, 0, 1, 1, 8'hA5));
    tbl.push_back(mk(1, 1, 8'h5A, 0, 0, 1, 8'hA5));
    tbl.push_back(mk(1, 1, 8'h5A, 1, 0, 1, 8'hA5));
    tbl.push_back(mk(1, 1, 8'h5A, 1, 1, 1, 8'h5A));
    tbl.push_back(mk(1, 0, 8'h00, 1, 1, 0, 8'h00));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc_start();
      idle_all();
      vf[tbl[i].m] = tbl[i].v;
      df[tbl[i].m] = tbl[i].d;
      rb[tbl[i].m] = tbl[i].r;
      @(negedge clk);
      chk($sformatf("tbl%0d_rdy", i), rf[tbl[i].m], tbl[i].e_rdy);
      chk($sformatf("tbl%0d_vld", i), vb[tbl[i].m], tbl[i].e_vld);
      if (tbl[i].e_vld) chk($sformatf("tbl%0d_dat", i), db[tbl[i].m], tbl[i].e_dat);
    end

    // MODE0 x4: one word through an idle pipe appears 4 cycles after acceptance.
    cyc_start();
    idle_all();
    rb[0] = 1'b1;
    vf[0] = 1'b1;
    df[0] = 8'h3C;
    @(negedge clk);
    chk("lat_accept", rf[0], 1);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      cyc_start();
      vf[0] = 1'b0;
      @(negedge clk);
      if (vb[0]) begin
        lat = c;
        break;
      end
    end
    chk("lat_m0", lat, 4);
    chk("lat_data", db[0], 8'h3C);

    // MODE0 x4: fill to capacity, then in and out in the same cycle without a bubble.
    cyc_start();
    idle_all();
    for (int i = 0; i < 4; i++) begin
      vf[0] = 1'b1;
      df[0] = 8'h40 + 8'(i);
      @(negedge clk);
      chk($sformatf("fill%0d", i), rf[0], 1);
      cyc_start();
    end
    vf[0] = 1'b1;
    df[0] = 8'h44;
    @(negedge clk);
    chk("full_stall", rf[0], 0);
    cyc_start();
    rb[0] = 1'b1;
    @(negedge clk);
    chk("full_nobubble", rf[0], 1);
    chk("full_head", db[0], 8'h40);
    for (int i = 5; i < 10; i++) begin
      cyc_start();
      df[0] = 8'h40 + 8'(i);
      @(negedge clk);
      chk($sformatf("stream%0d", i), rf[0], 1);
    end
    cyc_start();
    vf[0] = 1'b0;
    repeat (10) cyc_start();

    // Reset while MODE2 holds two words.
    idle_all();
    vf[2] = 1'b1;
    df[2] = 8'h11;
    cyc_start();
    df[2] = 8'h22;
    cyc_start();
    vf[2] = 1'b0;
    @(negedge clk);
    chk("pre_rst_rdy", rf[2], 0);
    chk("pre_rst_vld", vb[2], 1);
    cyc_start();
    rst = 1'b0;
    cyc_start();
    @(negedge clk);
    chk("rst_vld_m2", vb[2], 0);
    chk("rst_rdy_m2", rf[2], 0);
    cyc_start();
    rst   = 1'b1;
    rb[2] = 1'b1;
    @(negedge clk);
    chk("rel_rdy_m2", rf[2], 1);
    chk("rel_vld_m2", vb[2], 0);
    for (int i = 0; i < 3; i++) begin
      cyc_start();
      @(negedge clk);
      chk($sformatf("no_stale%0d", i), vb[2], 0);
    end

    // MODE2: 20 back-to-back beats, counter wraps at 16.
    for (int i = 0; i < 20; i++) begin
      cyc_start();
      vf[2] = 1'b1;
      df[2] = 8'(i + 1);
      @(negedge clk);
      chk($sformatf("b2b%0d", i), rf[2], 1);
      if (i > 0) chk($sformatf("b2b_dat%0d", i), db[2], 8'(i));
    end
    cyc_start();
    vf[2] = 1'b0;
    repeat (4) cyc_start();
`ifdef PIPE_SLICE_STATS_EN
    @(negedge clk);
    chk("beat_wrap", bc[2], 4);
    chk("occ_end", oc2, 0);
`endif

    // Random traffic on each instance; offers are held until accepted.
    for (int m = 0; m < 3; m++) begin
      idle_all();
      pend = 1'b0;
      for (int c = 0; c < ((m == 0) ? 2000 : 800); c++) begin
        cyc_start();
        if (!pend) begin
          vf[m] = ($urandom % 4) != 0;
          df[m] = 8'($urandom);
        end
        rb[m] = ($urandom % 3) != 0;
        @(negedge clk);
        pend = vf[m] && !rf[m];
      end
      cyc_start();
      vf[m] = 1'b0;
      rb[m] = 1'b1;
      repeat (12) cyc_start();
    end
    @(negedge clk);
    chk("drain0", g_mon[0].q.size(), 0);
    chk("drain1", g_mon[1].q.size(), 0);
    chk("drain2", g_mon[2].q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_slice.md
Name: pipe_slice

Overview:
- Parametrised valid/ready register slice. Successor to the single-stage backward skid buffer.
- Selectable mode: forward-registered, backward-registered, or full skid (both directions registered).
- Configurable data width and a cascade of 1..4 identical stages.
- Inserted on long valid/ready paths between pipeline blocks to break timing on data/valid, on ready, or on both.

Parameters:
- L, 8, data width in bits (>=1).
- MODE, 2, 0 = forward (data/valid registered, ready combinational); 1 = backward (ready registered, data/valid combinational through); 2 = full skid (all outputs registered).
- STAGES, 1, number of cascaded slices, 1..4; stage k's _b side feeds stage k+1's _f side.
- CNT_W, 16, statistics counter width (used only with PIPE_SLICE_STATS_EN).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- valid_f  input  1  upstream valid.
- data_f  input  L  upstream data.
- ready_f  output  1  ready to upstream.
- valid_b  output  1  valid to downstream.
- data_b  output  L  data to downstream.
- ready_b  input  1  downstream ready.
- beat_cnt  output  CNT_W  accepted output beats (only with PIPE_SLICE_STATS_EN).
- occ  output  $clog2(2*STAGES+1)  words currently held (only with PIPE_SLICE_STATS_EN).

Behaviour:
- Reset and clock: reset rst, synchronous, active-low; clock clk.
- Transfer definitions: in = valid_f&&ready_f; out = valid_b&&ready_b. No word is lost, duplicated or reordered.
- While rst=0:
  - valid_b=0 and ready_f=0 in all modes (the combinational ready of MODE 0 is gated by rst).
  - Internal valids clear; data registers are not reset; data_b is don't-care while valid_b=0.
- First cycle after release: ready_f=1.
- Handshake rules:
  - Upstream holds data_f stable while valid_f && !ready_f.
  - Once valid_b rises, it stays high with stable data_b until out.
  - valid_f while ready_f=0 is ignored.
- MODE 0 (per stage):
  - One output register; ready_f = ready_b || !valid_b.
  - Latency 1 cycle; throughput 1/cycle; capacity 1.
- MODE 1 (per stage):
  - One skid register sk/sk_v; ready_f = !sk_v (registered).
  - valid_b = valid_f || sk_v; data_b = sk_v ? sk : data_f.
  - sk captures when in && !ready_b; sk_v clears on out.
  - Latency 0; throughput 1/cycle; capacity 1.
- MODE 2 (per stage), FSM EMPTY/BUSY/FULL with output register ob and skid register sk:
  - Outputs: ready_f = (state!=FULL), registered; valid_b = (state!=EMPTY).
  - EMPTY: in -> ob<=data_f, BUSY.
  - BUSY:
    - in&&out -> ob<=data_f, stay BUSY.
    - in&&!out -> sk<=data_f, FULL.
    - !in&&out -> EMPTY.
    - else hold.
  - FULL: out -> ob<=sk, BUSY; else hold. No in possible.
  - Latency 1 cycle; throughput 1/cycle; capacity 2.
- Cascade:
  - Total latency = STAGES (MODE 0/2) or 0 (MODE 1).
  - Capacity = STAGES (MODE 0/1) or 2*STAGES (MODE 2).
- Boundary conditions:
  - Simultaneous in and out when full-capacity (MODE 0, ready_b=1): accepted, no bubble.
  - Reset mid-operation: all held words discarded, valid_b=0 on the next edge.
  - MODE or STAGES out of range: elaboration error (generate-time check).

Optional Feature:
- Macro: PIPE_SLICE_STATS_EN.
- Defined:
  - beat_cnt increments by 1 per out and wraps at 2^CNT_W; cleared by reset.
  - occ = number of valid words across all stages, updated the same edge as the transfer (+1 on in, -1 on out, net 0 when both).
- Undefined: both ports and all their logic are absent; datapath behaviour is identical.

Test Plan:
- MODE=2, STAGES=1, ready_b=1, stream 0x01..0x10 back-to-back -> valid_b from cycle 1; data_b 0x01..0x10 one per cycle; ready_f stays 1.
- MODE=2, STAGES=1, drop ready_b for 3 cycles mid-stream -> FULL after 1 stall cycle; ready_f=0 the cycle after; after ready_b returns, order continues with no loss and no duplicate.
- MODE=1, ready_b=0 with one word offered -> word enters skid, ready_f=0 next cycle, data_b shows skid value; ready_b=1 -> ready_f=1 next cycle.
- MODE=0, STAGES=4, random valid_f/ready_b for 2000 cycles -> output sequence equals input sequence; latency 4 when unstalled.
- Assert rst=0 while MODE=2 holds 2 words -> next edge valid_b=0, ready_f=0; after release ready_f=1 and no stale word appears.
- With PIPE_SLICE_STATS_EN, CNT_W=4, 20 beats -> beat_cnt=4 (wrapped); occ tracks 0..2 and ends at 0.
